// File: rtl/icache_pkg.sv
// Shared instruction-cache widths and miss-sequencer state encoding.
// Used by the miss handler, the memory controller and the cache arrays.
package icache_pkg;

  localparam int ADDR_W   = 16;
  localparam int WORD_W   = 20;
  localparam int NWORDS   = 16;
  localparam int OFFSET_W = 4;
  localparam int INDEX_W  = 4;
  localparam int TAG_W    = ADDR_W - OFFSET_W - INDEX_W;
  localparam int BLOCK_W  = WORD_W * NWORDS;
  localparam int CNT_W    = OFFSET_W + 1;

  localparam logic [1:0] S_IDLE       = 2'd0;
  localparam logic [1:0] S_WAIT_WORD  = 2'd1;
  localparam logic [1:0] S_WAIT_BLOCK = 2'd2;
  localparam logic [1:0] S_FILL       = 2'd3;

endpackage

// File: rtl/instr_miss_handler_if.sv
// Fetch, memory-controller and fill-side signals of the miss handler.
// slave = the handler itself, master = whatever drives it.
interface instr_miss_handler_if
  import icache_pkg::*;
#(
  parameter int ADDR_WIDTH  = ADDR_W,
  parameter int WORD_WIDTH  = WORD_W,
  parameter int INDEX_WIDTH = INDEX_W,
  parameter int BLOCK_WIDTH = BLOCK_W,
  parameter int TAG_WIDTH   = TAG_W,
  parameter int NCNT_WIDTH  = CNT_W
);

  logic                   i_halt;
  logic [ADDR_WIDTH-1:0]  i_fetch_addr;
  logic                   i_fetch_addr_valid;
  logic                   i_tag_hit;
  logic [ADDR_WIDTH-1:0]  o_block_addr;
  logic                   o_block_addr_valid;
  logic [BLOCK_WIDTH-1:0] i_mem_block_data;
  logic [NCNT_WIDTH-1:0]  i_mem_num_words_rcvd;
  logic                   i_mem_data_received;
  logic [WORD_WIDTH-1:0]  o_word;
  logic                   o_word_valid;
  logic                   o_stall;
  logic [TAG_WIDTH-1:0]   o_fill_tag;
  logic [INDEX_WIDTH-1:0] o_fill_index;
  logic [BLOCK_WIDTH-1:0] o_fill_data;
  logic                   o_fill_valid;

  modport slave (
    input  i_halt,
    input  i_fetch_addr,
    input  i_fetch_addr_valid,
    input  i_tag_hit,
    output o_block_addr,
    output o_block_addr_valid,
    input  i_mem_block_data,
    input  i_mem_num_words_rcvd,
    input  i_mem_data_received,
    output o_word,
    output o_word_valid,
    output o_stall,
    output o_fill_tag,
    output o_fill_index,
    output o_fill_data,
    output o_fill_valid
  );

  modport master (
    output i_halt,
    output i_fetch_addr,
    output i_fetch_addr_valid,
    output i_tag_hit,
    input  o_block_addr,
    input  o_block_addr_valid,
    output i_mem_block_data,
    output i_mem_num_words_rcvd,
    output i_mem_data_received,
    input  o_word,
    input  o_word_valid,
    input  o_stall,
    input  o_fill_tag,
    input  o_fill_index,
    input  o_fill_data,
    input  o_fill_valid
  );

endinterface

// File: rtl/block_word_mux.sv
// Selects one instruction word out of an assembled cache block.
module block_word_mux #(
  parameter int WORD_WIDTH = 20,
  parameter int NUM_WORDS  = 16,
  parameter int OFF_W      = 4
) (
  input  logic [WORD_WIDTH*NUM_WORDS-1:0] block_i,
  input  logic [OFF_W-1:0]                off_i,
  output logic [WORD_WIDTH-1:0]           word_o
);

  always_comb begin
    word_o = '0;
    for (int k = 0; k < NUM_WORDS; k++) begin
      if (off_i == OFF_W'(k)) begin
        word_o = block_i[k*WORD_WIDTH +: WORD_WIDTH];
      end
    end
  end

endmodule

// File: rtl/instr_miss_handler.sv
// I-cache miss sequencer: block request, early-restart word
// forwarding and a single-cycle fill write once the block is in.
module instr_miss_handler
  import icache_pkg::*;
#(
  parameter int ADDR_WIDTH        = ADDR_W,
  parameter int WORD_WIDTH        = WORD_W,
  parameter int NUM_WORDS_P_BLOCK = NWORDS,
  parameter int INDEX_WIDTH       = INDEX_W,
  parameter int BLOCK_WIDTH       = BLOCK_W
) (
  input logic                clk,
  input logic                arst_n,
  instr_miss_handler_if.slave bus
);

  localparam int OFF_W = $clog2(NUM_WORDS_P_BLOCK);
  localparam int TAGW  = ADDR_WIDTH - OFF_W - INDEX_WIDTH;

  logic [1:0]             state_q, state_d;
  logic [ADDR_WIDTH-1:0]  miss_addr_q, miss_addr_d;
  logic [WORD_WIDTH-1:0]  word_q, word_d;
  logic                   word_valid_q, word_valid_d;
  logic [BLOCK_WIDTH-1:0] fill_data_q, fill_data_d;

  logic [OFF_W-1:0]      off;
  logic [OFF_W:0]        off_ext;
  logic [WORD_WIDTH-1:0] sel_word;
  logic                  word_rdy;
  logic                  miss;
  logic                  blk_done;
  logic                  req_out;

  assign off      = miss_addr_q[OFF_W-1:0];
  assign off_ext  = {1'b0, off};
  assign word_rdy = bus.i_mem_num_words_rcvd > off_ext;
  assign miss     = bus.i_fetch_addr_valid & ~bus.i_tag_hit;
  assign blk_done = bus.i_mem_data_received;

  block_word_mux #(
    .WORD_WIDTH (WORD_WIDTH),
    .NUM_WORDS  (NUM_WORDS_P_BLOCK),
    .OFF_W      (OFF_W)
  ) u_mux (
    .block_i (bus.i_mem_block_data),
    .off_i   (off),
    .word_o  (sel_word)
  );

  always_comb begin
    state_d      = state_q;
    miss_addr_d  = miss_addr_q;
    word_d       = word_q;
    word_valid_d = 1'b0;
    fill_data_d  = fill_data_q;
    unique case (state_q)
      S_IDLE: begin
        if (miss) begin
          miss_addr_d = bus.i_fetch_addr;
          state_d     = S_WAIT_WORD;
        end
      end
      S_WAIT_WORD: begin
        // block completion implies the missed word is present too
        if (word_rdy | blk_done) begin
          word_d       = sel_word;
          word_valid_d = 1'b1;
          state_d      = blk_done ? S_FILL : S_WAIT_BLOCK;
        end
        if (blk_done) begin
          fill_data_d = bus.i_mem_block_data;
        end
      end
      S_WAIT_BLOCK: begin
        if (blk_done) begin
          fill_data_d = bus.i_mem_block_data;
          state_d     = S_FILL;
        end
      end
      S_FILL: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!arst_n) begin
      state_q      <= S_IDLE;
      miss_addr_q  <= '0;
      word_q       <= '0;
      word_valid_q <= 1'b0;
      fill_data_q  <= '0;
    end else if (!bus.i_halt) begin
      state_q      <= state_d;
      miss_addr_q  <= miss_addr_d;
      word_q       <= word_d;
      word_valid_q <= word_valid_d;
      fill_data_q  <= fill_data_d;
    end
  end

  assign req_out = (state_q == S_WAIT_WORD) |
                   (state_q == S_WAIT_BLOCK);

  assign bus.o_block_addr_valid = req_out;
  assign bus.o_block_addr =
    req_out ? {miss_addr_q[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}}
            : '0;
  assign bus.o_stall = state_q != S_IDLE;

  // halted pulses stay latched and fire once halt drops
  assign bus.o_word_valid = word_valid_q & ~bus.i_halt;
  assign bus.o_word       = word_q;
  assign bus.o_fill_valid = (state_q == S_FILL) & ~bus.i_halt;
  assign bus.o_fill_data  = fill_data_q;
  assign bus.o_fill_tag   = miss_addr_q[ADDR_WIDTH-1 -: TAGW];
  assign bus.o_fill_index = miss_addr_q[OFF_W +: INDEX_WIDTH];

endmodule

// File: tb/tb_instr_miss_handler.sv
// Directed table-driven bench for the I-cache miss handler.
module tb_instr_miss_handler;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  instr_miss_handler_if bus ();

  instr_miss_handler dut (
    .clk    (clk),
    .arst_n (rst_n),
    .bus    (bus)
  );

  typedef struct {
    logic        halt;
    logic [15:0] fa;
    logic        fv;
    logic        hit;
    logic [4:0]  nw;
    logic        dr;
    logic        st;
    logic        bav;
    logic [15:0] ba;
    logic        wv;
    logic [19:0] wd;
    logic        fl;
    logic [7:0]  tag;
    logic [3:0]  idx;
  } vec_t;

  vec_t tbl[32];
  logic [319:0] blk;

  function automatic logic [19:0] w(input int k);
    return 20'(k * 32'h1111 + 5);
  endfunction

  function automatic vec_t v(
    input logic h, input logic [15:0] fa, input logic fv,
    input logic hit, input logic [4:0] nw, input logic dr,
    input logic st, input logic bav, input logic [15:0] ba,
    input logic wv, input logic [19:0] wd, input logic fl,
    input logic [7:0] tag, input logic [3:0] idx);
    vec_t r;
    r.halt = h;  r.fa = fa;   r.fv = fv;   r.hit = hit;
    r.nw = nw;   r.dr = dr;   r.st = st;   r.bav = bav;
    r.ba = ba;   r.wv = wv;   r.wd = wd;   r.fl = fl;
    r.tag = tag; r.idx = idx;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [319:0] act,
                     input logic [319:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic h, input logic [15:0] fa,
                       input logic fv, input logic hit,
                       input logic [4:0] nw, input logic dr);
    bus.i_halt               = h;
    bus.i_fetch_addr         = fa;
    bus.i_fetch_addr_valid   = fv;
    bus.i_tag_hit            = hit;
    bus.i_mem_num_words_rcvd = nw;
    bus.i_mem_data_received  = dr;
  endtask

  initial begin
    for (int k = 0; k < 16; k++) blk[k*20 +: 20] = w(k);
    bus.i_mem_block_data = blk;
    drive(0, 16'h0, 0, 0, 5'd0, 0);
    rst_n = 1'b0;

    //    h  fa        fv hit nw  dr  st bav ba        wv wd      fl tag    idx
    tbl[0]  = v(0,16'h1234,1,1,5'd0, 0, 0,0,16'h0000,0,20'h0 ,0,8'h00,4'h0);
    tbl[1]  = v(0,16'h0000,0,0,5'd0, 0, 0,0,16'h0000,0,20'h0 ,0,8'h00,4'h0);
    tbl[2]  = v(0,16'h0000,0,0,5'd16,1, 0,0,16'h0000,0,20'h0 ,0,8'h00,4'h0);
    tbl[3]  = v(0,16'h1230,1,0,5'd0, 0, 0,0,16'h0000,0,20'h0 ,0,8'h00,4'h0);
    tbl[4]  = v(0,16'h0000,0,0,5'd0, 0, 1,1,16'h1230,0,20'h0 ,0,8'h12,4'h3);
    tbl[5]  = v(0,16'h0000,0,0,5'd2, 0, 1,1,16'h1230,0,20'h0 ,0,8'h12,4'h3);
    tbl[6]  = v(0,16'h5550,1,0,5'd2, 0, 1,1,16'h1230,1,w(0)  ,0,8'h12,4'h3);
    tbl[7]  = v(0,16'h0000,0,0,5'd4, 0, 1,1,16'h1230,0,w(0)  ,0,8'h12,4'h3);
    tbl[8]  = v(0,16'h0000,0,0,5'd16,1, 1,1,16'h1230,0,w(0)  ,0,8'h12,4'h3);
    tbl[9]  = v(0,16'h0000,0,0,5'd0, 0, 1,0,16'h0000,0,w(0)  ,1,8'h12,4'h3);
    tbl[10] = v(0,16'hABCF,1,0,5'd0, 0, 0,0,16'h0000,0,w(0)  ,0,8'h12,4'h3);
    tbl[11] = v(0,16'h0000,0,0,5'd14,0, 1,1,16'hABC0,0,w(0)  ,0,8'hAB,4'hC);
    tbl[12] = v(0,16'h0000,0,0,5'd16,1, 1,1,16'hABC0,0,w(0)  ,0,8'hAB,4'hC);
    tbl[13] = v(0,16'h0000,0,0,5'd0, 0, 1,0,16'h0000,1,w(15) ,1,8'hAB,4'hC);
    tbl[14] = v(0,16'h4567,1,0,5'd0, 0, 0,0,16'h0000,0,w(15) ,0,8'hAB,4'hC);
    tbl[15] = v(0,16'h0000,0,0,5'd8, 0, 1,1,16'h4560,0,w(15) ,0,8'h45,4'h6);
    tbl[16] = v(0,16'h0000,0,0,5'd8, 0, 1,1,16'h4560,1,w(7)  ,0,8'h45,4'h6);
    tbl[17] = v(0,16'h0000,0,0,5'd16,1, 1,1,16'h4560,0,w(7)  ,0,8'h45,4'h6);
    tbl[18] = v(1,16'h0000,0,0,5'd0, 0, 1,0,16'h0000,0,w(7)  ,0,8'h45,4'h6);
    tbl[19] = v(1,16'h0000,0,0,5'd0, 0, 1,0,16'h0000,0,w(7)  ,0,8'h45,4'h6);
    tbl[20] = v(1,16'h0000,0,0,5'd0, 0, 1,0,16'h0000,0,w(7)  ,0,8'h45,4'h6);
    tbl[21] = v(0,16'h0000,0,0,5'd0, 0, 1,0,16'h0000,0,w(7)  ,1,8'h45,4'h6);
    tbl[22] = v(0,16'h2222,1,0,5'd0, 0, 0,0,16'h0000,0,w(7)  ,0,8'h45,4'h6);
    tbl[23] = v(0,16'h0000,0,0,5'd4, 0, 1,1,16'h2220,0,w(7)  ,0,8'h22,4'h2);
    tbl[24] = v(1,16'h0000,0,0,5'd4, 0, 1,1,16'h2220,0,w(2)  ,0,8'h22,4'h2);
    tbl[25] = v(0,16'h0000,0,0,5'd4, 0, 1,1,16'h2220,1,w(2)  ,0,8'h22,4'h2);
    tbl[26] = v(0,16'h0000,0,0,5'd16,1, 1,1,16'h2220,0,w(2)  ,0,8'h22,4'h2);
    tbl[27] = v(0,16'h3338,1,0,5'd0, 0, 1,0,16'h0000,0,w(2)  ,1,8'h22,4'h2);
    tbl[28] = v(0,16'h3338,1,0,5'd0, 0, 0,0,16'h0000,0,w(2)  ,0,8'h22,4'h2);
    tbl[29] = v(0,16'h0000,0,0,5'd0, 1, 1,1,16'h3330,0,w(2)  ,0,8'h33,4'h3);
    tbl[30] = v(0,16'h0000,0,0,5'd0, 0, 1,0,16'h0000,1,w(8)  ,1,8'h33,4'h3);
    tbl[31] = v(0,16'h0000,0,0,5'd0, 0, 0,0,16'h0000,0,w(8)  ,0,8'h33,4'h3);

    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst stall", 320'(bus.o_stall), 320'(0));
    chk("rst bav", 320'(bus.o_block_addr_valid), 320'(0));
    chk("rst fill", 320'(bus.o_fill_valid), 320'(0));
    chk("rst fdata", bus.o_fill_data, 320'(0));
    rst_n = 1'b1;

    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      drive(tbl[i].halt, tbl[i].fa, tbl[i].fv, tbl[i].hit,
            tbl[i].nw, tbl[i].dr);
      #1;
      chk($sformatf("r%0d stall", i), 320'(bus.o_stall),
          320'(tbl[i].st));
      chk($sformatf("r%0d bav", i), 320'(bus.o_block_addr_valid),
          320'(tbl[i].bav));
      chk($sformatf("r%0d baddr", i), 320'(bus.o_block_addr),
          320'(tbl[i].ba));
      chk($sformatf("r%0d wvalid", i), 320'(bus.o_word_valid),
          320'(tbl[i].wv));
      chk($sformatf("r%0d word", i), 320'(bus.o_word),
          320'(tbl[i].wd));
      chk($sformatf("r%0d fvalid", i), 320'(bus.o_fill_valid),
          320'(tbl[i].fl));
      chk($sformatf("r%0d tag", i), 320'(bus.o_fill_tag),
          320'(tbl[i].tag));
      chk($sformatf("r%0d idx", i), 320'(bus.o_fill_index),
          320'(tbl[i].idx));
      if (tbl[i].fl)
        chk($sformatf("r%0d fdata", i), bus.o_fill_data, blk);
    end

    // reset while waiting for the missed word
    @(negedge clk);
    drive(0, 16'h9876, 1, 0, 5'd0, 0);
    @(negedge clk);
    drive(0, 16'h0000, 0, 0, 5'd0, 0);
    #1;
    chk("mid baddr", 320'(bus.o_block_addr), 320'(16'h9870));
    chk("mid stall", 320'(bus.o_stall), 320'(1));
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("mrst stall", 320'(bus.o_stall), 320'(0));
    chk("mrst bav", 320'(bus.o_block_addr_valid), 320'(0));
    chk("mrst baddr", 320'(bus.o_block_addr), 320'(0));
    chk("mrst wvalid", 320'(bus.o_word_valid), 320'(0));
    chk("mrst word", 320'(bus.o_word), 320'(0));
    chk("mrst tag", 320'(bus.o_fill_tag), 320'(0));
    chk("mrst idx", 320'(bus.o_fill_index), 320'(0));
    chk("mrst fdata", bus.o_fill_data, 320'(0));
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      drive(0, 16'h0000, 0, 0, 5'd16, c < 3);
      #1;
      chk($sformatf("late%0d fvalid", c), 320'(bus.o_fill_valid),
          320'(0));
      chk($sformatf("late%0d stall", c), 320'(bus.o_stall),
          320'(0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
